// File: rtl/bus_drvr_fifo.sv
// bus_drvr_fifo: first-word-fall-through packet FIFO between a terminal driver
// and a bus arbiter. It keeps sticky overflow/underflow flags and a saturating
// counter of dropped pushes.
module bus_drvr_fifo #(
    parameter int pckg_sz = 16,
    parameter int depth   = 8,
    parameter int cnt_w   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [pckg_sz-1:0]           D_push,
    input  logic                         pop,
    output logic [pckg_sz-1:0]           D_pop,
    output logic                         pndng,
    output logic                         full,
    output logic [$clog2(depth+1)-1:0]   count,
    input  logic                         clr_ovf,
    output logic                         overflow,
    output logic                         underflow,
    output logic [cnt_w-1:0]             drop_cnt
);

    localparam int PW = (depth > 1) ? $clog2(depth) : 1;
    localparam int CW = $clog2(depth + 1);

    localparam logic [PW-1:0]    PTR_LAST = PW'(depth - 1);
    localparam logic [CW-1:0]    CNT_FULL = CW'(depth);
    localparam logic [cnt_w-1:0] DROP_MAX = '1;
    localparam logic [cnt_w-1:0] DROP_ONE = cnt_w'(1);

    logic [pckg_sz-1:0] mem [depth];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;

    logic               do_push;
    logic               do_pop;
    logic               drop;
    logic               uf_evt;
    logic [CW-1:0]      count_nxt;

    // Decode this cycle's requests against the registered occupancy flags.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        do_push   = 1'b0;
        do_pop    = 1'b0;
        drop      = 1'b0;
        uf_evt    = 1'b0;
        count_nxt = count;
        if (!reset) begin
            do_pop  = pop && pndng;
            // A write into a full FIFO only fits when the head leaves on the same edge.
            do_push = push && (!full || do_pop);
            drop    = push && full && !pop;
            uf_evt  = pop && !pndng;
            count_nxt = count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Packet storage; pointers define validity, so the array carries no reset.
    always_ff @(posedge clk) begin
        // NOTE: memories are left unreset; a reset only needs to clear the pointers and count.
        if (do_push) begin
            mem[wr_ptr] <= D_push;
        end
    end

    // Pointers, occupancy and status flags.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            pndng     <= 1'b0;
            full      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            // Explicit wrap at depth-1 keeps non-power-of-two depths correct.
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            count <= count_nxt;
            pndng <= (count_nxt != '0);
            full  <= (count_nxt == CNT_FULL);

            // A clear coinciding with a new event leaves that event recorded.
            if (clr_ovf) begin
                overflow  <= drop;
                underflow <= uf_evt;
                drop_cnt  <= drop ? DROP_ONE : '0;
            end else begin
                overflow  <= overflow | drop;
                underflow <= underflow | uf_evt;
                if (drop && (drop_cnt != DROP_MAX)) begin
                    drop_cnt <= drop_cnt + DROP_ONE;
                end
            end
        end
    end

    // Head packet is visible combinationally from the registered read pointer.
    always_comb begin
        D_pop = pndng ? mem[rd_ptr] : '0;
    end

endmodule

// File: tb/tb_bus_drvr_fifo.sv
// tb_bus_drvr_fifo: directed test of bus_drvr_fifo at depth 8 (s=0) and at
// depth 5 with a 2-bit drop counter (s=1), using a queue-based scoreboard.
module tb_bus_drvr_fifo;

    logic        clk = 1'b0;
    logic        reset;

    logic        push0, pop0, clr0;
    logic [15:0] din0, dout0;
    logic        pn0, fu0, ov0, un0;
    logic [3:0]  cnt0;
    logic [7:0]  dc0;

    logic        push1, pop1, clr1;
    logic [15:0] din1, dout1;
    logic        pn1, fu1, ov1, un1;
    logic [2:0]  cnt1;
    logic [1:0]  dc1;

    int checks = 0;
    int errors = 0;

    logic [15:0] q0[$];
    logic [15:0] q1[$];
    int m_ovf[2];
    int m_uf[2];
    int m_dc[2];

    always #5 clk = ~clk;

    bus_drvr_fifo #(.pckg_sz(16), .depth(8), .cnt_w(8)) dut (
        .clk(clk), .reset(reset), .push(push0), .D_push(din0), .pop(pop0),
        .D_pop(dout0), .pndng(pn0), .full(fu0), .count(cnt0), .clr_ovf(clr0),
        .overflow(ov0), .underflow(un0), .drop_cnt(dc0)
    );

    bus_drvr_fifo #(.pckg_sz(16), .depth(5), .cnt_w(2)) dut5 (
        .clk(clk), .reset(reset), .push(push1), .D_push(din1), .pop(pop1),
        .D_pop(dout1), .pndng(pn1), .full(fu1), .count(cnt1), .clr_ovf(clr1),
        .overflow(ov1), .underflow(un1), .drop_cnt(dc1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic get(input int s, output logic [31:0] c, output logic [31:0] pn,
                       output logic [31:0] fu, output logic [31:0] dp,
                       output logic [31:0] ov, output logic [31:0] un,
                       output logic [31:0] dc);
        if (s == 0) begin
            c = 32'(cnt0); pn = 32'(pn0); fu = 32'(fu0); dp = 32'(dout0);
            ov = 32'(ov0); un = 32'(un0); dc = 32'(dc0);
        end else begin
            c = 32'(cnt1); pn = 32'(pn1); fu = 32'(fu1); dp = 32'(dout1);
            ov = 32'(ov1); un = 32'(un1); dc = 32'(dc1);
        end
    endtask

    task automatic idle_inputs();
        push0 = 0; pop0 = 0; clr0 = 0; din0 = '0;
        push1 = 0; pop1 = 0; clr1 = 0; din1 = '0;
    endtask

    // One clock of traffic on instance s, checked against the scoreboard.
    task automatic op(input int s, input bit pu, input bit po, input bit cl, input logic [15:0] d);
        int dep, satmax, sz;
        bit do_pop, drop, acc, uf;
        logic [15:0] exp_d;
        logic [31:0] c, pn, fu, dp, ov, un, dc;
        dep    = (s == 0) ? 8 : 5;
        satmax = (s == 0) ? 255 : 3;
        sz     = (s == 0) ? q0.size() : q1.size();
        if (s == 0) begin push0 = pu; pop0 = po; clr0 = cl; din0 = d; end
        else        begin push1 = pu; pop1 = po; clr1 = cl; din1 = d; end

        do_pop = po && (sz != 0);
        drop   = pu && (sz == dep) && !po;
        acc    = pu && !drop;
        uf     = po && (sz == 0);

        if (do_pop) begin
            exp_d = (s == 0) ? q0.pop_front() : q1.pop_front();
            get(s, c, pn, fu, dp, ov, un, dc);
            check($sformatf("s%0d pop_data", s), dp, 32'(exp_d));
        end
        if (acc) begin
            if (s == 0) q0.push_back(d); else q1.push_back(d);
        end
        if (cl) begin
            m_ovf[s] = drop ? 1 : 0;
            m_uf[s]  = uf ? 1 : 0;
            m_dc[s]  = drop ? 1 : 0;
        end else begin
            if (drop) m_ovf[s] = 1;
            if (uf) m_uf[s] = 1;
            if (drop && m_dc[s] < satmax) m_dc[s]++;
        end

        @(posedge clk); #1;
        idle_inputs();
        sz = (s == 0) ? q0.size() : q1.size();
        exp_d = (sz == 0) ? 16'h0 : ((s == 0) ? q0[0] : q1[0]);
        get(s, c, pn, fu, dp, ov, un, dc);
        check($sformatf("s%0d count", s), c, 32'(sz));
        check($sformatf("s%0d pndng", s), pn, 32'(sz != 0));
        check($sformatf("s%0d full", s), fu, 32'(sz == dep));
        check($sformatf("s%0d head", s), dp, 32'(exp_d));
        check($sformatf("s%0d overflow", s), ov, 32'(m_ovf[s]));
        check($sformatf("s%0d underflow", s), un, 32'(m_uf[s]));
        check($sformatf("s%0d drop_cnt", s), dc, 32'(m_dc[s]));
    endtask

    // Reset for n cycles with optional competing requests on s0; every output must read zero.
    task automatic do_reset(input int n, input bit pu, input bit po, input bit cl);
        logic [31:0] c, pn, fu, dp, ov, un, dc;
        for (int i = 0; i < n; i++) begin
            reset = 1'b1;
            push0 = pu; pop0 = po; clr0 = cl; din0 = 16'hDEAD;
            @(posedge clk); #1;
            q0.delete(); q1.delete();
            for (int k = 0; k < 2; k++) begin m_ovf[k] = 0; m_uf[k] = 0; m_dc[k] = 0; end
            for (int s = 0; s < 2; s++) begin
                get(s, c, pn, fu, dp, ov, un, dc);
                check($sformatf("s%0d rst count", s), c, 0);
                check($sformatf("s%0d rst pndng", s), pn, 0);
                check($sformatf("s%0d rst full", s), fu, 0);
                check($sformatf("s%0d rst D_pop", s), dp, 0);
                check($sformatf("s%0d rst overflow", s), ov, 0);
                check($sformatf("s%0d rst underflow", s), un, 0);
                check($sformatf("s%0d rst drop_cnt", s), dc, 0);
            end
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();

        // Reset held for two cycles; outputs stay at reset values throughout.
        do_reset(2, 1'b0, 1'b0, 1'b0);

        // Single packet in and out.
        op(0, 1, 0, 0, 16'h1ABC);
        op(0, 0, 1, 0, 16'h0);

        // Fill, overflow one packet, drain in order.
        for (int i = 1; i <= 8; i++) op(0, 1, 0, 0, 16'(i));
        op(0, 1, 0, 0, 16'h0009);
        for (int i = 0; i < 8; i++) op(0, 0, 1, 0, 16'h0);
        op(0, 0, 0, 1, 16'h0);

        // Simultaneous push and pop while full.
        for (int i = 1; i <= 8; i++) op(0, 1, 0, 0, 16'(i));
        op(0, 1, 1, 0, 16'h00FF);
        for (int i = 0; i < 8; i++) op(0, 0, 1, 0, 16'h0);

        // Underflow, then clear coinciding with a drop.
        op(0, 0, 1, 0, 16'h0);
        op(0, 0, 0, 1, 16'h0);
        for (int i = 1; i <= 8; i++) op(0, 1, 0, 0, 16'(16'h0100 + i));
        op(0, 1, 0, 1, 16'h0BAD);
        op(0, 1, 0, 0, 16'h0BAE);
        for (int i = 0; i < 8; i++) op(0, 0, 1, 0, 16'h0);
        // Clear coinciding with an underflow keeps underflow set.
        op(0, 0, 1, 1, 16'h0);
        // Push and pop while empty: store, ignore pop, flag underflow.
        op(0, 0, 0, 1, 16'h0);
        op(0, 1, 1, 0, 16'h0777);
        op(0, 1, 1, 0, 16'h0778);
        op(0, 0, 1, 0, 16'h0);

        // Depth 5: mixed traffic crossing the pointer wrap.
        for (int i = 0; i < 13; i++) op(1, i < 10, i >= 3, 0, 16'(16'h0200 + i));
        while (q1.size() != 0) op(1, 0, 1, 0, 16'h0);
        // Depth 5 overflow saturation of the 2-bit counter.
        for (int i = 0; i < 5; i++) op(1, 1, 0, 0, 16'(16'h0300 + i));
        for (int i = 0; i < 5; i++) op(1, 1, 0, 0, 16'(16'h0400 + i));
        op(1, 1, 1, 0, 16'h0500);
        for (int i = 0; i < 5; i++) op(1, 0, 1, 0, 16'h0);

        // Reset mid-operation with a competing push.
        for (int i = 0; i < 3; i++) op(0, 1, 0, 0, 16'(16'h0A00 + i));
        do_reset(1, 1'b1, 1'b1, 1'b1);
        op(0, 1, 0, 0, 16'h0042);
        op(0, 0, 1, 0, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
